// File: rtl/memory_pkg.sv
// Shared types and constants for the memory handshake (responder and controller).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Command encoding on memory_command, shared with the multicycle controller.
  localparam logic MEMORY_READ  = 1'b0;
  localparam logic MEMORY_WRITE = 1'b1;

  // Word index carried by a byte address: drop the byte-lane bits.
  function automatic logic [29:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/memory_array.sv
// Single-port 2^ADDR_WIDTH x 32 synchronous RAM with byte-lane write mask and registered read port.
// Latency: read data appears in rdata one edge after an enabled read; writes commit on the same edge.
// Backpressure: none; accepts an access on every enabled cycle. rd_clear zeroes the read register.
module memory_array #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rd_clear,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            mask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Byte-masked write port; only lanes with a set mask bit are updated.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: cleared on demand, otherwise loaded only by a read and held across writes.
  always_ff @(posedge clk) begin
    if (rd_clear) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory handshake responder: one request at a time, completed by a one-cycle memory_valid pulse.
// Latency: accept in cycle T -> memory_valid in T+LATENCY; memory_ready returns in T+LATENCY+1.
// Backpressure: memory_ready low outside IDLE; enables while not ready are ignored. Option: MEMORY_ACCESS_FAULT_EN.
module memory_responder
  import memory_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_write_mask,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] memory_read_data,
  output logic        memory_access_fault
);

  // Counter only has to hold LATENCY-2 (the WAIT cycles after the first).
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  accept;
  logic                  access_fire;
  logic                  array_en;

  logic                  req_cmd;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           req_wdata;
  logic [3:0]            req_mask;

  logic                  acc_cmd;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_mask;
  logic                  acc_oor;
  logic [29:0]           word_addr;
  logic                  unused_addr;

  assign word_addr = byte_to_word(memory_address);
  assign accept    = (state == IDLE) && memory_enable && !reset;

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, handshake outputs and the array-access strobe.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    memory_ready = 1'b0;
    memory_valid = 1'b0;
    access_fire  = 1'b0;
    case (state)
      IDLE: begin
        memory_ready = !reset;
        if (memory_enable && !reset) begin
          if (LATENCY == 1) begin
            state_nxt   = RESPOND;
            access_fire = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt   = RESPOND;
          access_fire = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESPOND: begin
        memory_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, loaded on the accept edge for use by a later array access.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_cmd   <= memory_command;
      req_idx   <= word_addr[ADDR_WIDTH-1:0];
      req_wdata <= memory_write_data;
      req_mask  <= memory_write_mask;
    end
  end

  // With LATENCY=1 the access happens on the accept edge, so it uses the live request.
  assign acc_cmd   = (state == IDLE) ? memory_command              : req_cmd;
  assign acc_idx   = (state == IDLE) ? word_addr[ADDR_WIDTH-1:0]   : req_idx;
  assign acc_wdata = (state == IDLE) ? memory_write_data           : req_wdata;
  assign acc_mask  = (state == IDLE) ? memory_write_mask           : req_mask;

  // Reset drops a pending request before it can touch the array.
  assign array_en = access_fire && !reset;

`ifdef MEMORY_ACCESS_FAULT_EN
  logic in_oor;
  logic req_oor;
  logic fault_q;

  assign in_oor      = |memory_address[31:ADDR_WIDTH+2];
  assign acc_oor     = (state == IDLE) ? in_oor : req_oor;
  assign unused_addr = ^memory_address[1:0];

  // Out-of-range flag travels with the request.
  always_ff @(posedge clk) begin
    if (accept) req_oor <= in_oor;
  end

  // Fault reflects the most recent completion; updated on the edge entering RESPOND.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (array_en) begin
      fault_q <= acc_oor;
    end
  end

  assign memory_access_fault = fault_q;
`else
  // Upper address bits alias into the array; no fault reporting.
  assign acc_oor             = 1'b0;
  assign unused_addr         = ^{memory_address[31:ADDR_WIDTH+2], memory_address[1:0]};
  assign memory_access_fault = 1'b0;
`endif

  memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_memory_array (
    .clk      (clk),
    .rd_clear (reset || (array_en && acc_oor)),
    .en       (array_en && !acc_oor),
    .we       (acc_cmd == MEMORY_WRITE),
    .mask     (acc_mask),
    .addr     (acc_idx),
    .wdata    (acc_wdata),
    .rdata    (memory_read_data)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (LATENCY 1 and 3) checked against a behavioural model.
// Latency: model predicts the completion cycle as accept cycle + LATENCY.
// Backpressure: driver waits on memory_ready before each request; hold-enable runs check ready spacing.
module tb_memory_responder;
  import memory_pkg::*;

  localparam int AW   = 12;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
`ifdef MEMORY_ACCESS_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        en   [2];
  logic        cmd  [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  msk  [2];
  logic        rdy  [2];
  logic        vld  [2];
  logic [31:0] rdat [2];
  logic        flt  [2];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        sbq0[$];
  exp_t        sbq1[$];
  logic [31:0] mdl [2][32];
  logic [31:0] last_rd [2];
  bit          pend_rdy [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT0)) u_lat1 (
    .clk(clk), .reset(rst[0]), .memory_enable(en[0]), .memory_command(cmd[0]),
    .memory_address(addr[0]), .memory_write_data(wdat[0]), .memory_write_mask(msk[0]),
    .memory_ready(rdy[0]), .memory_valid(vld[0]), .memory_read_data(rdat[0]),
    .memory_access_fault(flt[0]));

  memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) u_lat3 (
    .clk(clk), .reset(rst[1]), .memory_enable(en[1]), .memory_command(cmd[1]),
    .memory_address(addr[1]), .memory_write_data(wdat[1]), .memory_write_mask(msk[1]),
    .memory_ready(rdy[1]), .memory_valid(vld[1]), .memory_read_data(rdat[1]),
    .memory_access_fault(flt[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (lat%0d, cycle %0d): got %h expected %h", name, lat_of(d), cyc, act, exp);
  endtask

  // Reference: plain word array per instance, byte merge for writes, last-read register.
  task automatic model(input int d, input logic c, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] m, input int due);
    exp_t e;
    int   wi;
    wi    = int'(a[6:2]);
    e.due = due;
    if (FAULT_EN && (a[31:AW+2] != '0)) begin
      last_rd[d] = 32'h0;
      e.flt      = 1'b1;
    end else begin
      e.flt = 1'b0;
      if (c == MEMORY_WRITE) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) mdl[d][wi][8*b +: 8] = w[8*b +: 8];
      end else begin
        last_rd[d] = mdl[d][wi];
      end
    end
    e.rd = last_rd[d];
    if (d == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic wait_ready(input int d);
    int guard = 0;
    @(negedge clk);
    while (!rdy[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy[d]) check("ready_timeout", d, 32'(rdy[d]), 32'd1);
  endtask

  // One request: wait for ready, present it for one cycle, record the expectation.
  task automatic issue(input int d, input logic c, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] m, input bit commit);
    wait_ready(d);
    en[d] = 1'b1; cmd[d] = c; addr[d] = a; wdat[d] = w; msk[d] = m;
    if (commit) model(d, c, a, w, m, cyc + lat_of(d));
    @(negedge clk);
    en[d] = 1'b0;
    cmd[d] = 1'($urandom); addr[d] = $urandom; wdat[d] = $urandom; msk[d] = 4'($urandom);
  endtask

  // Enable held high: a new request may only start every LATENCY+1 cycles.
  task automatic hold_enable(input int d, input int n);
    int t0;
    wait_ready(d);
    t0 = cyc;
    en[d] = 1'b1; cmd[d] = MEMORY_READ; addr[d] = 32'h14; wdat[d] = $urandom; msk[d] = 4'hF;
    for (int k = 0; k < n; k++) begin
      check("hold_ready_spacing", d, 32'(rdy[d]), 32'(((cyc - t0) % (lat_of(d) + 1)) == 0));
      if (rdy[d]) model(d, MEMORY_READ, 32'h14, 32'h0, 4'hF, cyc + lat_of(d));
      @(negedge clk);
    end
    en[d] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & 32'h3) | (32'($urandom_range(0, 31)) << 2);
    if ($urandom_range(0, 3) == 0) a[31:AW+2] = 18'($urandom_range(1, 262143));
    return a;
  endfunction

  task automatic run_seq(input int d);
    for (int i = 0; i < 32; i++) issue(d, MEMORY_WRITE, 32'(i * 4), $urandom, 4'hF, 1'b1);
    issue(d, MEMORY_WRITE, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(d, MEMORY_READ,  32'h10, 32'h0, 4'h0, 1'b1);
    issue(d, MEMORY_WRITE, 32'h10, 32'h0000AA00, 4'b0010, 1'b1);
    issue(d, MEMORY_READ,  32'h10, 32'h0, 4'h0, 1'b1);
    issue(d, MEMORY_WRITE, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1);
    issue(d, MEMORY_READ,  32'h10, 32'h0, 4'h0, 1'b1);
    issue(d, MEMORY_READ,  32'h8000_0000, 32'h0, 4'h0, 1'b1);
    issue(d, MEMORY_READ,  32'h10, 32'h0, 4'h0, 1'b1);
    hold_enable(d, 12);
    if (d == 1) begin
      issue(d, MEMORY_WRITE, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
      issue(d, MEMORY_WRITE, 32'h20, 32'h12345678, 4'hF, 1'b0);
      // Now in the first WAIT cycle of the uncommitted write.
      rst[d] = 1'b1;
      check("ready_in_reset", d, 32'(rdy[d]), 32'd0);
      @(negedge clk);
      rst[d] = 1'b0;
      last_rd[d] = 32'h0;
      check("rdata_after_reset", d, rdat[d], 32'h0);
      check("fault_after_reset", d, 32'(flt[d]), 32'd0);
      issue(d, MEMORY_READ, 32'h20, 32'h0, 4'h0, 1'b1);
    end
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(d, 1'($urandom), rand_addr(), $urandom, 4'($urandom), 1'b1);
    end
  endtask

  // Monitor: pop and compare whenever an instance presents memory_valid.
  task automatic monitor_step(input int d);
    exp_t e;
    if (pend_rdy[d]) begin
      pend_rdy[d] = 1'b0;
      if (!rst[d]) check("ready_after_valid", d, 32'(rdy[d]), 32'd1);
    end
    if (vld[d]) begin
      check("ready_in_valid", d, 32'(rdy[d]), 32'd0);
      if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
        check("valid_without_request", d, 32'(vld[d]), 32'd0);
      end else begin
        e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
        check("valid_cycle", d, 32'(cyc), 32'(e.due));
        check("read_data", d, rdat[d], e.rd);
        check("access_fault", d, 32'(flt[d]), 32'(e.flt));
        pend_rdy[d] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0);
    monitor_step(1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; cmd[d] = 1'b0; addr[d] = '0; wdat[d] = '0; msk[d] = '0;
      last_rd[d] = 32'h0; pend_rdy[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", d, 32'(rdy[d]), 32'd0);
      check("reset_valid", d, 32'(vld[d]), 32'd0);
      check("reset_rdata", d, rdat[d], 32'h0);
      rst[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("idle_ready", d, 32'(rdy[d]), 32'd1);
      check("idle_valid", d, 32'(vld[d]), 32'd0);
      check("idle_rdata", d, rdat[d], 32'h0);
      check("idle_fault", d, 32'(flt[d]), 32'd0);
    end
    fork
      run_seq(0);
      run_seq(1);
    join
    repeat (8) @(negedge clk);
    check("drained_lat1", 0, 32'(sbq0.size()), 32'd0);
    check("drained_lat3", 1, 32'(sbq1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
